ccx_emem_arbiter: RTL

Two-port round-robin arbiter that shares the core complex's single external memory bus (`emem_*`) between the CPU core's external port (requester 0) and a second bus master such as a debug or DMA engine (requester 1). It sits between `ccx_top` and the SoC fabric. It registers bus ownership so that a selected request stays routed until the memory grants it. An optional watchdog terminates transactions that are never granted.

---
 rtl/ccx_emem_arb_pkg.sv | 20 ++
 rtl/ccx_emem_arb_timer.sv | 29 ++
 rtl/ccx_emem_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ccx_emem_arb_pkg.sv
// Shared types and widths for the external-memory arbiter: FSM state, owner one-hot codes, bus widths.
// Pure declarations, no latency; backpressure is carried by req/gnt on the ports that use these.
package ccx_emem_arb_pkg;

    localparam int ADDR_W = 39;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;
    localparam int TMR_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_e;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_S0   = 2'b01;
    localparam logic [1:0] OWNER_S1   = 2'b10;

endpackage

// File: rtl/ccx_emem_arb_timer.sv
// Watchdog counter for an owned emem request; o_hit flags TIMEOUT_CYCLES-1 waiting cycles.
// Zero-latency hit decode from the registered count; no backpressure of its own.
module ccx_emem_arb_timer
    import ccx_emem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic f_clk,
    input  logic g_reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_hit
);

    logic [TMR_W-1:0] r_cnt;

    always_ff @(posedge f_clk or posedge g_reset) begin
        if (g_reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_hit = (r_cnt == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ccx_emem_arbiter.sv
// Round-robin owner of the single emem bus for CPU (s0) and second master (s1); one arbitration cycle from IDLE,
// request path combinational while owned, owner held until emem_gnt. Optional watchdog: CCX_EMEM_ARB_TIMEOUT_EN.
module ccx_emem_arbiter
    import ccx_emem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              f_clk,
    input  logic              g_reset,
    input  logic              s0_req,
    input  logic              s0_rtype,
    input  logic [ADDR_W-1:0] s0_addr,
    input  logic              s0_wen,
    input  logic [STRB_W-1:0] s0_strb,
    input  logic [DATA_W-1:0] s0_wdata,
    input  logic              s1_req,
    input  logic              s1_rtype,
    input  logic [ADDR_W-1:0] s1_addr,
    input  logic              s1_wen,
    input  logic [STRB_W-1:0] s1_strb,
    input  logic [DATA_W-1:0] s1_wdata,
    output logic              s0_gnt,
    output logic              s0_err,
    output logic [DATA_W-1:0] s0_rdata,
    output logic              s1_gnt,
    output logic              s1_err,
    output logic [DATA_W-1:0] s1_rdata,
    output logic              emem_req,
    output logic              emem_rtype,
    output logic [ADDR_W-1:0] emem_addr,
    output logic              emem_wen,
    output logic [STRB_W-1:0] emem_strb,
    output logic [DATA_W-1:0] emem_wdata,
    input  logic              emem_gnt,
    input  logic              emem_err,
    input  logic [DATA_W-1:0] emem_rdata,
    output logic [1:0]        arb_owner
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("ccx_emem_arbiter: TIMEOUT_CYCLES out of range");
    end

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    logic       r_last;
    logic       w_own;
    logic       w_sel1;
    logic       w_own_req;
    logic       w_other_req;
    logic       w_timeout;
    logic       w_done;

    assign w_own       = (r_state != IDLE);
    assign w_sel1      = (r_state == OWN1);
    assign w_own_req   = w_sel1 ? s1_req : s0_req;
    assign w_other_req = w_sel1 ? s0_req : s1_req;

`ifdef CCX_EMEM_ARB_TIMEOUT_EN
    logic w_tmr_hit;

    ccx_emem_arb_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .f_clk  (f_clk),
        .g_reset(g_reset),
        .i_clr  (w_state_nxt != r_state),
        .i_inc  (w_own & ~emem_gnt),
        .o_hit  (w_tmr_hit)
    );

    // A real grant in the expiry cycle takes precedence over the forced error.
    assign w_timeout = w_tmr_hit & w_own & ~emem_gnt;
`else
    assign w_timeout = 1'b0;
`endif

    assign w_done = w_own & (emem_gnt | w_timeout);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                // On a tie the requester that did not complete last wins.
                if (s0_req & (~s1_req | r_last)) begin
                    w_state_nxt = OWN0;
                end else if (s1_req) begin
                    w_state_nxt = OWN1;
                end
            end
            default: begin
                if (w_done) begin
                    if (w_other_req) begin
                        w_state_nxt = w_sel1 ? OWN0 : OWN1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (!w_own_req) begin
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge f_clk or posedge g_reset) begin
        if (g_reset) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_done) begin
                r_last <= w_sel1;
            end
        end
    end

    assign emem_req   = w_own & w_own_req & ~w_timeout;
    assign emem_rtype = w_own & (w_sel1 ? s1_rtype : s0_rtype);
    assign emem_addr  = w_own ? (w_sel1 ? s1_addr : s0_addr) : '0;
    assign emem_wen   = w_own & (w_sel1 ? s1_wen : s0_wen);
    assign emem_strb  = w_own ? (w_sel1 ? s1_strb : s0_strb) : '0;
    assign emem_wdata = w_own ? (w_sel1 ? s1_wdata : s0_wdata) : '0;

    assign s0_gnt   = (r_state == OWN0) & (emem_gnt | w_timeout);
    assign s1_gnt   = (r_state == OWN1) & (emem_gnt | w_timeout);
    assign s0_err   = (r_state == OWN0) & (emem_gnt ? emem_err : w_timeout);
    assign s1_err   = (r_state == OWN1) & (emem_gnt ? emem_err : w_timeout);
    assign s0_rdata = emem_rdata;
    assign s1_rdata = emem_rdata;

    assign arb_owner = (r_state == OWN0) ? OWNER_S0 :
                       (r_state == OWN1) ? OWNER_S1 : OWNER_NONE;

endmodule
